// File: rtl/multi_cycle_control_if.sv
// multi_cycle_control_if: opcode/funct/mem_ready in, datapath strobes out; jal_link only with MCC_JAL_EN
interface multi_cycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, BNE, LUI;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic       mem_err;
  logic       illegal;
`ifdef MCC_JAL_EN
  logic       jal_link;
`endif
  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    output MemtoReg, RegDst, RegWrite, ALUSrcA, BNE, LUI,
    output ALUSrcB, PCSource, ALUop, state, mem_err, illegal
`ifdef MCC_JAL_EN
    , output jal_link
`endif
  );
  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    input  MemtoReg, RegDst, RegWrite, ALUSrcA, BNE, LUI,
    input  ALUSrcB, PCSource, ALUop, state, mem_err, illegal
`ifdef MCC_JAL_EN
    , input jal_link
`endif
  );
endinterface

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multicycle MIPS control FSM with memory-wait timeout; MCC_JAL_EN adds the jal state
module multi_cycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  multi_cycle_control_if.master bus
);
  typedef enum logic [3:0] {
    S_IF, S_ID, S_MADR, S_MRD, S_MWB, S_MWR, S_EXE, S_AWB, S_BR, S_JMP, S_IEXE, S_IWB, S_JAL
  } state_e;
  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, bne, lui;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       mem_err, illegal;
`ifdef MCC_JAL_EN
    logic       jal_link;
`endif
  } ctl_t;
`ifdef MCC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st, tmo, r_ok;
  logic [2:0]       r_op, i_op;
  ctl_t             c;
  assign wait_st = state_q inside {S_IF, S_MRD, S_MWR};
  assign tmo     = TIMEOUT != 0 && wait_st && !bus.mem_ready && cnt_q == LAST;
  // counter only survives a self-loop while waiting; any state change clears it
  assign cnt_d   = (wait_st && !bus.mem_ready && !tmo) ? cnt_q + CNT_W'(!(&cnt_q)) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    r_op = 3'b000;
    r_ok = 1'b1;
    case (bus.funct)
      6'h20:   r_op = 3'b010;
      6'h22:   r_op = 3'b110;
      6'h24:   r_op = 3'b000;
      6'h25:   r_op = 3'b001;
      6'h2a:   r_op = 3'b111;
      6'h02:   r_op = 3'b101;
      6'h26:   r_op = 3'b011;
      default: r_ok = 1'b0;
    endcase
  end
  always_comb begin
    i_op = 3'b000;
    case (bus.opcode)
      6'h08, 6'h0f: i_op = 3'b010;
      6'h0a:        i_op = 3'b111;
      6'h0d:        i_op = 3'b001;
      6'h0e:        i_op = 3'b011;
      default:      i_op = 3'b000;
    endcase
  end
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:   state_d = bus.mem_ready ? S_ID : S_IF;
      S_ID:
        case (bus.opcode)
          6'h23, 6'h2b:                             state_d = S_MADR;
          6'h00:                                    state_d = S_EXE;
          6'h04, 6'h05:                             state_d = S_BR;
          6'h02:                                    state_d = S_JMP;
          6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f: state_d = S_IEXE;
          6'h03:                                    state_d = JAL_EN ? S_JAL : S_IF;
          default:                                  state_d = S_IF;
        endcase
      S_MADR: state_d = bus.opcode == 6'h23 ? S_MRD : bus.opcode == 6'h2b ? S_MWR : S_IF;
      S_MRD:  state_d = bus.mem_ready ? S_MWB : tmo ? S_IF : S_MRD;
      S_MWR:  state_d = (bus.mem_ready || tmo) ? S_IF : S_MWR;
      S_EXE:  state_d = r_ok ? S_AWB : S_IF;
      S_IEXE: state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end
  // a timed-out wait cycle drops its memory strobe and raises only mem_err
  always_comb begin
    c = '0;
    case (state_q)
      S_IF: begin
        c.mem_read  = !tmo;
        c.ir_write  = bus.mem_ready;
        c.pc_write  = bus.mem_ready;
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b010;
        c.mem_err   = tmo;
      end
      S_ID: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = 3'b010;
        c.illegal   = state_d == S_IF;
      end
      S_MADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 3'b010;
      end
      S_MRD: begin
        c.mem_read = !tmo;
        c.iord     = 1'b1;
        c.mem_err  = tmo;
      end
      S_MWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        c.mem_write = !tmo;
        c.iord      = 1'b1;
        c.mem_err   = tmo;
      end
      S_EXE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = r_op;
        c.illegal   = !r_ok;
      end
      S_AWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BR: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b110;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.bne           = bus.opcode == 6'h05;
      end
      S_JMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_IEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = i_op;
        c.lui       = bus.opcode == 6'h0f;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
        c.lui       = bus.opcode == 6'h0f;
      end
      S_JAL: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.reg_write = 1'b1;
`ifdef MCC_JAL_EN
        c.jal_link  = 1'b1;
`endif
      end
      default: ;
    endcase
  end
  assign {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
          bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.BNE, bus.LUI,
          bus.ALUSrcB, bus.PCSource, bus.ALUop, bus.mem_err, bus.illegal
`ifdef MCC_JAL_EN
          , bus.jal_link
`endif
         } = rst_n ? c : '0;
  assign bus.state = rst_n ? state_q : S_IF;
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: scoreboard bench, TIMEOUT=4; expected state/outputs queued per driven cycle
module tb_multi_cycle_control;
  typedef struct packed {
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, BNE, LUI;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [2:0] ALUop;
    logic       mem_err, illegal;
  } outs_t;
  typedef struct {
    string      tag;
    logic [3:0] st;
    outs_t      o;
    outs_t      m;
    logic       jl;
  } exp_t;
  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  exp_t  q[$];
  outs_t got;
  multi_cycle_control_if bus();
  multi_cycle_control #(.TIMEOUT(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign got = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.BNE, bus.LUI,
                bus.ALUSrcB, bus.PCSource, bus.ALUop, bus.mem_err, bus.illegal};
  task automatic check(input string tag, input logic [31:0] g, input logic [31:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, g, e);
    end
  endtask
  function automatic outs_t f_if(input logic rdy);
    outs_t o = '0;
    o.MemRead = 1'b1; o.ALUSrcB = 2'b01; o.ALUop = 3'b010; o.IRWrite = rdy; o.PCWrite = rdy;
    return o;
  endfunction
  function automatic outs_t f_if_tmo();
    outs_t o = '0;
    o.ALUSrcB = 2'b01; o.ALUop = 3'b010; o.mem_err = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_id(input logic ill);
    outs_t o = '0;
    o.ALUSrcB = 2'b11; o.ALUop = 3'b010; o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t f_madr();
    outs_t o = '0;
    o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUop = 3'b010;
    return o;
  endfunction
  function automatic outs_t f_mrd();
    outs_t o = '0;
    o.MemRead = 1'b1; o.IorD = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_mwb();
    outs_t o = '0;
    o.RegWrite = 1'b1; o.MemtoReg = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_mwr(input logic t);
    outs_t o = '0;
    o.MemWrite = !t; o.IorD = 1'b1; o.mem_err = t;
    return o;
  endfunction
  function automatic outs_t f_exe(input logic [2:0] op);
    outs_t o = '0;
    o.ALUSrcA = 1'b1; o.ALUop = op;
    return o;
  endfunction
  function automatic outs_t f_awb();
    outs_t o = '0;
    o.RegWrite = 1'b1; o.RegDst = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_br(input logic bne);
    outs_t o = '0;
    o.ALUSrcA = 1'b1; o.ALUop = 3'b110; o.PCWriteCond = 1'b1; o.PCSource = 2'b01; o.BNE = bne;
    return o;
  endfunction
  function automatic outs_t f_jmp(input logic rw);
    outs_t o = '0;
    o.PCWrite = 1'b1; o.PCSource = 2'b10; o.RegWrite = rw;
    return o;
  endfunction
  function automatic outs_t f_iexe(input logic [2:0] op, input logic lui);
    outs_t o = '0;
    o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUop = op; o.LUI = lui;
    return o;
  endfunction
  function automatic outs_t f_iwb(input logic lui);
    outs_t o = '0;
    o.RegWrite = 1'b1; o.LUI = lui;
    return o;
  endfunction
  task automatic step(input logic r, input logic [5:0] opc, input logic [5:0] fn, input logic rdy,
                      input logic [3:0] st, input outs_t o, input string tag,
                      input outs_t m = '1, input logic jl = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    bus.opcode = opc;
    bus.funct = fn;
    bus.mem_ready = rdy;
    e.tag = tag; e.st = st; e.o = o; e.m = m; e.jl = jl;
    q.push_back(e);
  endtask
  task automatic fetch(input logic [5:0] opc, input logic [5:0] fn, input string tag);
    step(1'b1, opc, fn, 1'b1, 4'd0, f_if(1'b1), {tag, "_if"});
    step(1'b1, opc, fn, 1'b1, 4'd1, f_id(1'b0), {tag, "_id"});
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.tag, "/state"}, 32'(bus.state), 32'(e.st));
      check({e.tag, "/outs"}, 32'(got & e.m), 32'(e.o & e.m));
`ifdef MCC_JAL_EN
      check({e.tag, "/jal_link"}, 32'(bus.jal_link), 32'(e.jl));
`endif
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [5:0] r_fn[7]  = '{6'h22, 6'h20, 6'h24, 6'h25, 6'h2a, 6'h02, 6'h26};
    logic [2:0] r_op[7]  = '{3'b110, 3'b010, 3'b000, 3'b001, 3'b111, 3'b101, 3'b011};
    logic [5:0] i_opc[6] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    logic [2:0] i_alu[6] = '{3'b010, 3'b111, 3'b000, 3'b001, 3'b011, 3'b010};
    outs_t ill_o = '0;
    outs_t ill_m = '0;
    ill_o.illegal = 1'b1;
    ill_m.illegal = 1'b1;
    bus.opcode = 6'h3f; bus.funct = 6'h3f; bus.mem_ready = 1'b1;
    step(1'b0, 6'h3f, 6'h3f, 1'b1, 4'd0, '0, "rst0");
    step(1'b0, 6'h3f, 6'h3f, 1'b1, 4'd0, '0, "rst1");
    step(1'b1, 6'h3f, 6'h3f, 1'b1, 4'd0, f_if(1'b1), "rel_if");
    step(1'b1, 6'h3f, 6'h3f, 1'b1, 4'd1, f_id(1'b1), "ill_id");
    for (int i = 0; i < 7; i++) begin
      fetch(6'h00, r_fn[i], "r");
      step(1'b1, 6'h00, r_fn[i], 1'b1, 4'd6, f_exe(r_op[i]), "r_exe");
      step(1'b1, 6'h00, r_fn[i], 1'b1, 4'd7, f_awb(), "r_awb");
    end
    fetch(6'h00, 6'h3f, "badfn");
    step(1'b1, 6'h00, 6'h3f, 1'b1, 4'd6, ill_o, "badfn_exe", ill_m);
    fetch(6'h23, 6'h00, "lw");
    step(1'b1, 6'h23, 6'h00, 1'b1, 4'd2, f_madr(), "lw_madr");
    step(1'b1, 6'h23, 6'h00, 1'b1, 4'd3, f_mrd(), "lw_mrd");
    step(1'b1, 6'h23, 6'h00, 1'b1, 4'd4, f_mwb(), "lw_mwb");
    fetch(6'h23, 6'h00, "lws");
    step(1'b1, 6'h23, 6'h00, 1'b1, 4'd2, f_madr(), "lws_madr");
    for (int i = 0; i < 3; i++) step(1'b1, 6'h23, 6'h00, 1'b0, 4'd3, f_mrd(), "lws_wait");
    step(1'b1, 6'h23, 6'h00, 1'b1, 4'd3, f_mrd(), "lws_rdy");
    step(1'b1, 6'h23, 6'h00, 1'b1, 4'd4, f_mwb(), "lws_mwb");
    fetch(6'h2b, 6'h00, "sw");
    step(1'b1, 6'h2b, 6'h00, 1'b1, 4'd2, f_madr(), "sw_madr");
    step(1'b1, 6'h2b, 6'h00, 1'b1, 4'd5, f_mwr(1'b0), "sw_mwr");
    fetch(6'h04, 6'h00, "beq");
    step(1'b1, 6'h04, 6'h00, 1'b1, 4'd8, f_br(1'b0), "beq_br");
    fetch(6'h05, 6'h00, "bne");
    step(1'b1, 6'h05, 6'h00, 1'b1, 4'd8, f_br(1'b1), "bne_br");
    fetch(6'h02, 6'h00, "j");
    step(1'b1, 6'h02, 6'h00, 1'b1, 4'd9, f_jmp(1'b0), "j_jmp");
    for (int i = 0; i < 6; i++) begin
      fetch(i_opc[i], 6'h00, "imm");
      step(1'b1, i_opc[i], 6'h00, 1'b1, 4'd10, f_iexe(i_alu[i], i_opc[i] == 6'h0f), "imm_exe");
      step(1'b1, i_opc[i], 6'h00, 1'b1, 4'd11, f_iwb(i_opc[i] == 6'h0f), "imm_wb");
    end
    step(1'b1, 6'h03, 6'h00, 1'b1, 4'd0, f_if(1'b1), "jal_if");
`ifdef MCC_JAL_EN
    step(1'b1, 6'h03, 6'h00, 1'b1, 4'd1, f_id(1'b0), "jal_id");
    step(1'b1, 6'h03, 6'h00, 1'b1, 4'd12, f_jmp(1'b1), "jal_jal", '1, 1'b1);
`else
    step(1'b1, 6'h03, 6'h00, 1'b1, 4'd1, f_id(1'b1), "jal_ill");
`endif
    for (int i = 0; i < 3; i++) step(1'b1, 6'h00, 6'h20, 1'b0, 4'd0, f_if(1'b0), "if_wait");
    step(1'b1, 6'h00, 6'h20, 1'b0, 4'd0, f_if_tmo(), "if_tmo");
    for (int i = 0; i < 3; i++) step(1'b1, 6'h00, 6'h20, 1'b0, 4'd0, f_if(1'b0), "if_rewait");
    fetch(6'h00, 6'h20, "after_tmo");
    step(1'b1, 6'h00, 6'h20, 1'b1, 4'd6, f_exe(3'b010), "after_tmo_exe");
    step(1'b1, 6'h00, 6'h20, 1'b1, 4'd7, f_awb(), "after_tmo_awb");
    fetch(6'h2b, 6'h00, "swt");
    step(1'b1, 6'h2b, 6'h00, 1'b1, 4'd2, f_madr(), "swt_madr");
    for (int i = 0; i < 3; i++) step(1'b1, 6'h2b, 6'h00, 1'b0, 4'd5, f_mwr(1'b0), "swt_wait");
    step(1'b1, 6'h2b, 6'h00, 1'b0, 4'd5, f_mwr(1'b1), "swt_tmo");
    fetch(6'h00, 6'h20, "mid");
    step(1'b1, 6'h00, 6'h20, 1'b1, 4'd6, f_exe(3'b010), "mid_exe");
    step(1'b0, 6'h00, 6'h20, 1'b1, 4'd0, '0, "mid_rst");
    fetch(6'h00, 6'h20, "mid_rel");
    @(posedge clk);
    @(negedge clk);
    #1;
    check("drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter TIMEOUT, default 16: memory-wait cycles before abort; 0 disables timeout.
REQ-002 Parameter CNT_W, default 5: wait-counter width; SHALL satisfy 2^CNT_W > TIMEOUT.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; both valid from ID onward.
REQ-006 mem_ready  in  1  memory completes the current read/write this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, BNE, LUI  out  1 each  datapath strobes/selects.
REQ-008 ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2; PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
REQ-009 ALUop  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 101 srl, 011 xor.
REQ-010 state  out  4  current state code; mem_err, illegal  out  1  one-cycle abort pulses.

Function
REQ-011 States: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, EXE=6, AWB=7, BR=8, JMP=9, IEXE=10, IWB=11, JAL=12; codes 13-15 SHALL go to IF.
REQ-012 IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=010, PCSource=00; IRWrite=PCWrite=mem_ready; stay until mem_ready, then ID.
REQ-013 ID: ALUSrcA=0, ALUSrcB=11, ALUop=010; next: lw/sw(0x23/0x2b)->MADR, R(0x00)->EXE, beq/bne(0x04/0x05)->BR, j(0x02)->JMP, addi/slti/andi/ori/xori/lui(0x08/0x0a/0x0c/0x0d/0x0e/0x0f)->IEXE, else illegal=1 and IF.
REQ-014 MADR: ALUSrcA=1, ALUSrcB=10, ALUop=010; lw->MRD, sw->MWR.
REQ-015 MRD: MemRead=1, IorD=1, wait for mem_ready, then MWB; MWB: RegWrite=1, MemtoReg=1, RegDst=0, then IF.
REQ-016 MWR: MemWrite=1, IorD=1, wait for mem_ready, then IF.
REQ-017 EXE: ALUSrcA=1, ALUSrcB=00; ALUop from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2a slt, 0x02 srl, 0x26 xor; other funct: illegal=1, next IF, no AWB.
REQ-018 AWB: RegWrite=1, RegDst=1, MemtoReg=0, then IF.
REQ-019 BR: ALUSrcA=1, ALUSrcB=00, ALUop=110, PCWriteCond=1, PCSource=01, BNE=(opcode==0x05); then IF.
REQ-020 JMP: PCWrite=1, PCSource=10; then IF.
REQ-021 IEXE: ALUSrcA=1, ALUSrcB=10; ALUop addi 010, slti 111, andi 000, ori 001, xori 011, lui 010; LUI=(opcode==0x0f); then IWB.
REQ-022 IWB: RegWrite=1, RegDst=0, MemtoReg=0, LUI held as in IEXE; then IF.
REQ-023 Outputs not listed for a state SHALL be 0; all outputs are combinational from state, opcode, funct, mem_ready.
REQ-024 Latency with mem_ready constant 1: R/imm 4 cycles, lw 5, sw 4, branch 3, j 3.
REQ-025 Wait counter clears on entry to IF/MRD/MWR, increments each waiting cycle without mem_ready; at count==TIMEOUT-1 without mem_ready: mem_err=1, next IF, no strobe asserted that cycle.
REQ-026 mem_ready in the timeout cycle SHALL win: normal completion, no mem_err.
REQ-027 Counter SHALL saturate, never wrap; TIMEOUT=0 waits indefinitely.

Reset
REQ-028 rst_n low: state=IF, counter=0, every output 0 (combinationally gated) regardless of inputs.
REQ-029 Reset mid-instruction SHALL abort it; first cycle after release is IF with IF outputs.

Configuration
REQ-030 Macro MCC_JAL_EN: defined, opcode 0x03 in ID->JAL: PCWrite=1, PCSource=10, RegWrite=1, link select (output jal_link=1) writes PC to $31, then IF; undefined, 0x03 is illegal and jal_link port is absent.

Verification
REQ-031 Reset, rst_n=0 then 1, mem_ready=1 -> state=IF, MemRead=1, IRWrite=1 on first cycle, state=1 next.
REQ-032 opcode=0x00 funct=0x22, mem_ready=1 -> states 0,1,6,7,0; ALUop=110 in EXE; RegWrite=RegDst=1 in AWB.
REQ-033 lw with mem_ready low 3 cycles in MRD -> MRD held 4 cycles, MWB once, no mem_err.
REQ-034 TIMEOUT=4, mem_ready=0 in IF -> mem_err pulse on 4th IF cycle, IRWrite never 1.
REQ-035 opcode=0x05 -> BR with PCWriteCond=1, BNE=1, ALUop=110; opcode=0x3f -> illegal pulse in ID, next IF.
REQ-036 MCC_JAL_EN defined, opcode=0x03 -> states 0,1,12,0, PCWrite=RegWrite=jal_link=1 in JAL.
